// File: rtl/overlap_add_synth.sv
// Overlap-add frame-to-stream reconstruction with a circular accumulator and valid/ready output.
// Define OLA_GAIN_COMP_EN to apply the Q15 window-gain compensation before saturation.
module overlap_add_synth #(
  parameter int          N        = 256,
  parameter int          NF       = 512,
  parameter int          HOP      = 128,
  parameter logic [15:0] GAIN_Q15 = 16'h7685
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic        flush,
  output logic [15:0] sample_out,
  output logic        sample_out_valid,
  input  logic        sample_out_ready,
  output logic        busy
);
  localparam int AW = $clog2(N);
  localparam int KW = $clog2(NF);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                   state_q;
  logic signed [17:0]       acc_q [N];
  logic        [AW-1:0]     base_q, rd_q;
  logic        [KW-1:0]     k_q;
  logic        [CW-1:0]     cnt_q;
  logic                     flush_q;
  logic        [15:0]       out_q;
  logic                     vld_q, rdy_q, busy_q;

  logic                     accept, in_win, last_beat, load, done;
  logic        [AW:0]       wr_sum, base_sum;
  logic        [AW-1:0]     wr_idx, rd_nxt, base_nxt;
  logic signed [17:0]       acc_rd, beat_ext;
  logic signed [19:0]       scaled;
  logic        [15:0]       sat_val;

  assign accept    = frame_valid && rdy_q && (state_q != DRAIN);
  assign in_win    = k_q < KW'(N);
  assign last_beat = k_q == KW'(NF - 1);
  assign load      = (state_q == DRAIN) && (cnt_q != '0) && (!vld_q || sample_out_ready);
  assign done      = (state_q == DRAIN) && (cnt_q == '0) && vld_q && sample_out_ready;
  assign beat_ext  = {{2{frame_in[15]}}, frame_in};

  // Modulo-N wrap without assuming N is a power of two.
  assign wr_sum   = {1'b0, base_q} + {1'b0, k_q[AW-1:0]};
  assign wr_idx   = (wr_sum >= (AW+1)'(N)) ? AW'(wr_sum - (AW+1)'(N)) : wr_sum[AW-1:0];
  assign rd_nxt   = (rd_q == AW'(N - 1)) ? '0 : rd_q + 1'b1;
  assign base_sum = {1'b0, base_q} + (AW+1)'(HOP);
  assign base_nxt = (base_sum >= (AW+1)'(N)) ? AW'(base_sum - (AW+1)'(N)) : base_sum[AW-1:0];

  assign acc_rd = acc_q[rd_q];

`ifdef OLA_GAIN_COMP_EN
  logic signed [33:0] prod;
  assign prod   = 34'(acc_rd) * $signed({18'b0, GAIN_Q15});
  assign scaled = 20'(prod >>> 15);
`else
  logic unused_gain;
  assign unused_gain = ^GAIN_Q15;
  assign scaled      = 20'(acc_rd);
`endif

  always_comb begin
    sat_val = scaled[15:0];
    if (scaled > 20'sd32767)       sat_val = 16'h7FFF;
    else if (scaled < -20'sd32768) sat_val = 16'h8000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < N; i++) acc_q[i] <= '0;
      base_q  <= '0;
      rd_q    <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          rdy_q <= 1'b1;
          if (accept) begin
            if (in_win) acc_q[wr_idx] <= acc_q[wr_idx] + beat_ext;
            busy_q <= 1'b1;
            if (last_beat) begin
              k_q     <= '0;
              state_q <= DRAIN;
              rd_q    <= base_q;
              cnt_q   <= CW'(HOP);
              flush_q <= 1'b0;
              rdy_q   <= 1'b0;
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= ACCUM;
            end
          end else if (state_q == IDLE && flush && !frame_valid) begin
            state_q <= DRAIN;
            rd_q    <= base_q;
            cnt_q   <= CW'(N);
            flush_q <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          // Output register only advances when empty or being consumed.
          if (load) begin
            out_q        <= sat_val;
            vld_q        <= 1'b1;
            acc_q[rd_q]  <= '0;
            rd_q         <= rd_nxt;
            cnt_q        <= cnt_q - 1'b1;
          end else if (done) begin
            vld_q   <= 1'b0;
            base_q  <= flush_q ? '0 : base_nxt;
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign frame_ready      = rdy_q;
  assign sample_out       = out_q;
  assign sample_out_valid = vld_q;
  assign busy             = busy_q;
endmodule

// File: tb/tb_overlap_add_synth.sv
// Randomized directed bench for overlap_add_synth against a frame-level overlap-add model.
// Honors OLA_GAIN_COMP_EN the same way the design does.
module tb_overlap_add_synth;
  localparam int N = 256, NF = 512, HOP = 128;
  localparam longint G = 30341;

  logic        clk = 1'b0;
  logic        rst, frame_valid, frame_ready, flush, sample_out_valid, sample_out_ready, busy;
  logic [15:0] frame_in, sample_out;

  always #5 clk = ~clk;

  overlap_add_synth dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .flush(flush), .sample_out(sample_out),
    .sample_out_valid(sample_out_valid), .sample_out_ready(sample_out_ready), .busy(busy)
  );

  int          npass = 0, ntotal = 0;
  int          macc [N];
  int          mbase;
  logic [15:0] exp_q [$];
  logic [15:0] fbuf [NF];
  logic [15:0] last_out;

  function automatic logic [15:0] sat_scale(input int a);
    longint v = a;
`ifdef OLA_GAIN_COMP_EN
    v = (v * G) >>> 15;
`endif
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  function automatic void model_reset();
    foreach (macc[i]) macc[i] = 0;
    mbase = 0;
    exp_q.delete();
  endfunction

  function automatic void model_drain(input int n, input bit fl);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(sat_scale(macc[(mbase + i) % N]));
      macc[(mbase + i) % N] = 0;
    end
    mbase = fl ? 0 : (mbase + HOP) % N;
  endfunction

  function automatic void model_frame();
    for (int k = 0; k < N; k++) begin
      int v = $signed(fbuf[k]);
      macc[(mbase + k) % N] += v;
    end
    model_drain(HOP, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic fill(input int mode, input logic [15:0] val, input logic [15:0] pad);
    for (int i = 0; i < NF; i++)
      fbuf[i] = (i >= N) ? pad : (mode == 0 ? val : 16'($urandom));
  endtask

  task automatic send_frame(input bit gaps);
    int  i = 0, guard = 0;
    logic rdy;
    model_frame();
    while (i < NF) begin
      @(negedge clk);
      frame_valid = !(gaps && ($urandom_range(7) == 0));
      frame_in    = fbuf[i];
      rdy         = frame_ready;
      @(posedge clk);
      if (rdy && frame_valid) i++;
      if (++guard > 4 * NF) begin
        chk("frame_timeout", i, NF);
        break;
      end
    end
  endtask

  task automatic collect(input int n, input int st_at, input int st_len, input bit rnd, input bit poke);
    int          got = 0, cyc = 0;
    bit          held = 0, r;
    logic [15:0] hold = '0;
    while (got < n) begin
      @(negedge clk);
      flush = 1'b0;
      if (held) begin
        chk("hold_data", sample_out, hold);
        chk("hold_valid", sample_out_valid, 1);
      end
      if (cyc == 0) chk("first_not_yet", sample_out_valid, 0);
      if (cyc == 1) chk("first_latency", sample_out_valid, 1);
      r = !((cyc >= st_at && cyc < st_at + st_len) || (rnd && $urandom_range(3) == 0));
      if (cyc <= 1) r = 1'b1;
      sample_out_ready = r;
      frame_valid = poke ? 1'($urandom) : 1'b0;
      frame_in    = 16'($urandom);
      if (poke) chk("ready_in_drain", frame_ready, 0);
      held = sample_out_valid && !r;
      hold = sample_out;
      if (sample_out_valid && r) begin
        chk("sample", sample_out, exp_q.pop_front());
        last_out = sample_out;
        got++;
      end
      if (++cyc > 4000) begin
        chk("drain_timeout", got, n);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    frame_valid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", sample_out_valid, 0);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_flush();
    model_drain(N, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    collect(N, -10, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out", sample_out, 0);
    chk("rst_valid", sample_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", frame_ready, 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; frame_valid = 1'b0; frame_in = '0; flush = 1'b0; sample_out_ready = 1'b1;
    last_out = '0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // Constant frame, then an identical one for the overlap sum.
    fill(0, 16'h1000, 16'h0000);
    send_frame(0); collect(HOP, -10, 0, 0, 0);
`ifdef OLA_GAIN_COMP_EN
    chk("const_gain", last_out, 16'h0ED0);
`else
    chk("const_plain", last_out, 16'h1000);
`endif
    send_frame(1); collect(HOP, -10, 0, 0, 0);
    do_flush();

    // Positive and negative saturation of the overlap region.
    fill(0, 16'h7000, 16'h0000);
    send_frame(0); collect(HOP, -10, 0, 0, 0);
    send_frame(0); collect(HOP, -10, 0, 0, 0);
    chk("sat_pos", last_out, 16'h7FFF);
    do_flush();
    fill(0, 16'h9000, 16'h0000);
    send_frame(0); collect(HOP, -10, 0, 0, 0);
    send_frame(0); collect(HOP, -10, 0, 0, 0);
    chk("sat_neg", last_out, 16'h8000);
    do_flush();

    // Padding content must not reach the output.
    fill(0, 16'h1000, 16'h7FFF);
    send_frame(1); collect(HOP, -10, 0, 0, 0);
    do_flush();

    // Flush after one frame from a base of zero.
    fill(0, 16'h1000, 16'h0000);
    send_frame(0); collect(HOP, -10, 0, 0, 0);
    do_flush();

    // Backpressure mid-drain with stray frame_valid pulses.
    fill(1, 16'h0000, 16'h0000);
    send_frame(0); collect(HOP, 40, 5, 0, 1);

    // Random frames with random stalls.
    for (int f = 0; f < 3; f++) begin
      fill(1, 16'h0000, 16'($urandom));
      send_frame(1); collect(HOP, -10, 0, 1, f == 1);
    end
    do_flush();

    // Reset in the middle of a drain, then reconstruct from scratch.
    fill(1, 16'h0000, 16'h0000);
    send_frame(0);
    sample_out_ready = 1'b1;
    repeat (10) @(negedge clk);
    do_reset();
    fill(0, 16'h1000, 16'h0000);
    send_frame(0); collect(HOP, -10, 0, 0, 0);
    send_frame(0); collect(HOP, -10, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
